// File: rtl/imm_packer.sv
// Scatters a signed immediate into the I/S/B/J fields of a base instruction word, with a 2-entry output buffer and word addressing.
// Define IMM_PACKER_RANGE_CHECK_EN to enable range/alignment checking (out_err, err_cnt).
module imm_packer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_immsrc,
   input  logic [31:0]          in_imm,
   input  logic [31:0]          in_base,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [31:0]          out_addr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;

   logic [31:0]      pack_instr_c;
   logic             push_c;
   logic             pop_c;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next_c;
   logic             wr_ptr;
   logic             rd_ptr;
   logic [31:0]      addr_q;
   logic [31:0]      mem_instr [DEPTH];

   // Field scatter; the immediate is always truncated to the format's width
   always_comb begin
      pack_instr_c = in_base;
      case (in_immsrc)
         2'b00: pack_instr_c[31:20] = in_imm[11:0];
         2'b01: begin
            pack_instr_c[31:25] = in_imm[11:5];
            pack_instr_c[11:7]  = in_imm[4:0];
         end
         2'b10: begin
            pack_instr_c[31]    = in_imm[12];
            pack_instr_c[7]     = in_imm[11];
            pack_instr_c[30:25] = in_imm[10:5];
            pack_instr_c[11:8]  = in_imm[4:1];
         end
         default: begin
            pack_instr_c[31]    = in_imm[20];
            pack_instr_c[30:21] = in_imm[10:1];
            pack_instr_c[20]    = in_imm[11];
            pack_instr_c[19:12] = in_imm[19:12];
         end
      endcase
   end

   assign push_c = in_valid & in_ready;
   assign pop_c  = out_valid & out_ready;

   always_comb begin
      count_next_c = count;
      case ({push_c, pop_c})
         2'b10:   count_next_c = count + CNT_W'(1);
         2'b01:   count_next_c = count - CNT_W'(1);
         default: count_next_c = count;
      endcase
   end

   // Handshake flags are registered from the next count, so out_ready never reaches in_ready combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         addr_q    <= BASE_ADDR;
         for (int i = 0; i < DEPTH; i++) mem_instr[i] <= '0;
      end else begin
         if (push_c) begin
            mem_instr[wr_ptr] <= pack_instr_c;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop_c) begin
            rd_ptr <= ~rd_ptr;
            addr_q <= addr_q + 32'd4;
         end
         count     <= count_next_c;
         in_ready  <= (count_next_c != CNT_W'(DEPTH));
         out_valid <= (count_next_c != '0);
      end
   end

   assign out_instr = mem_instr[rd_ptr];
   assign out_addr  = addr_q;

`ifdef IMM_PACKER_RANGE_CHECK_EN
   logic                 pack_err_c;
   logic                 mem_err [DEPTH];
   logic [ERR_CNT_W-1:0] err_cnt_q;

   // Upper bits must be a pure sign extension; branch/jump offsets must be even
   always_comb begin
      pack_err_c = 1'b0;
      case (in_immsrc)
         2'b00, 2'b01: pack_err_c = !((&in_imm[31:11]) || !(|in_imm[31:11]));
         2'b10:        pack_err_c = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
         default:      pack_err_c = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_err[i] <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         if (push_c) mem_err[wr_ptr] <= pack_err_c;
         if (pop_c && out_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
   end

   assign out_err = mem_err[rd_ptr];
   assign err_cnt = err_cnt_q;
`else
   logic unused_imm_c;

   assign unused_imm_c = ^in_imm[31:21];
   assign out_err      = 1'b0;
   assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Scoreboard bench for imm_packer: directed cases plus randomized traffic against a mask-based packing model and an extender round-trip.
`timescale 1ns/1ps
module tb_imm_packer;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int unsigned ECW  = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid, in_ready, out_valid, out_ready, out_err;
   logic [1:0]     in_immsrc;
   logic [31:0]    in_imm, in_base, out_instr, out_addr;
   logic [ECW-1:0] err_cnt;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [1:0]  src;
      logic [31:0] imm;
      bit          ok;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_addr;
   int          exp_errcnt;
   bit          rand_mode = 0;

   imm_packer #(.BASE_ADDR(BASE), .ERR_CNT_W(ECW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_immsrc(in_immsrc), .in_imm(in_imm), .in_base(in_base),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .out_err(out_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference packing: clear the format's immediate field in base, OR in the shifted bit groups
   function automatic logic [31:0] model_pack(logic [1:0] s, logic [31:0] imm, logic [31:0] base);
      logic [31:0] mask, field;
      case (s)
         2'b00: begin mask = 32'hFFF0_0000; field = imm << 20; end
         2'b01: begin
            mask  = 32'hFE00_0F80;
            field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
         end
         2'b10: begin
            mask  = 32'hFE00_0F80;
            field = (((imm >> 12) & 32'h1) << 31) | (((imm >> 11) & 32'h1) << 7) |
                    (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8);
         end
         default: begin
            mask  = 32'hFFFF_F000;
            field = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                    (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
         end
      endcase
      return (base & ~mask) | field;
   endfunction

   function automatic bit model_ok(logic [1:0] s, logic [31:0] imm);
      int v;
      v = $signed(imm);
      case (s)
         2'b00, 2'b01: return (v >= -2048) && (v <= 2047);
         2'b10:        return (v >= -4096) && (v <= 4095) && (imm[0] == 1'b0);
         default:      return (v >= -(1 << 20)) && (v < (1 << 20)) && (imm[0] == 1'b0);
      endcase
   endfunction

   function automatic logic [31:0] extend(logic [31:0] i, logic [1:0] s);
      case (s)
         2'b00:   return {{20{i[31]}}, i[31:20]};
         2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
         2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   // Monitor: compare every output handshake against the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            check("unexpected_out", 32'(out_valid), 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            check("instr", out_instr, mon_e.instr);
            check("err", 32'(out_err), 32'(mon_e.err));
            check("addr", out_addr, exp_addr);
            check("err_cnt", 32'(err_cnt), 32'(exp_errcnt));
            if (mon_e.ok) check("roundtrip", extend(out_instr, mon_e.src), mon_e.imm);
            exp_addr = exp_addr + 32'd4;
            if (mon_e.err && (exp_errcnt < (1 << ECW) - 1)) exp_errcnt++;
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge
   task automatic push(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                       input logic [31:0] exp_instr);
      exp_t e;
      int   n;
      bit   done;
      n = 0;
      done = 0;
      in_valid = 1'b1; in_immsrc = src; in_imm = imm; in_base = base;
      e.instr = exp_instr; e.src = src; e.imm = imm; e.ok = model_ok(src, imm);
`ifdef IMM_PACKER_RANGE_CHECK_EN
      e.err = !e.ok;
`else
      e.err = 1'b0;
`endif
      while (!done && n < 1000) begin
         @(negedge clk);
         if (in_ready) begin
            sbq.push_back(e);
            done = 1;
         end
         @(posedge clk); #1;
         if (!done && rand_mode) out_ready = ($urandom_range(0, 3) != 0);
         n++;
      end
      in_valid = 1'b0;
      if (!done) check("push_timeout", 32'(done), 32'd1);
      else       check("valid_after_accept", 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(sbq.size()), 32'd0);
      @(posedge clk); #1;
      check("empty_after_drain", 32'(out_valid), 32'd0);
      check("ready_after_drain", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, imm;
      logic [1:0]  s;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_immsrc = '0; in_imm = '0; in_base = '0;
      exp_addr = BASE; exp_errcnt = 0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_addr", out_addr, BASE);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_release", 32'(in_ready), 32'd1);

      // I pack, one cycle latency
      push(2'b00, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013);
      drain();

      // S/B/J back-to-back with consumer always ready
      out_ready = 1'b1;
      push(2'b01, 32'd8,         32'h0000_2023, 32'h0000_2423);
      push(2'b10, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3);
      push(2'b11, 32'd8,         32'h0000_006F, 32'h0080_006F);
      drain();

      // Range and alignment errors
      push(2'b00, 32'd2048, 32'h0000_0013, 32'h8000_0013);
      push(2'b10, 32'd3,    32'h0000_0063, 32'h0000_0163);
      drain();
`ifdef IMM_PACKER_RANGE_CHECK_EN
      check("err_cnt_two", 32'(err_cnt), 32'd2);
`else
      check("err_cnt_zero", 32'(err_cnt), 32'd0);
`endif

      // Backpressure: third word held until the consumer drains
      out_ready = 1'b0;
      push(2'b00, 32'd1, 32'h0000_0013, 32'h0010_0013);
      push(2'b00, 32'd2, 32'h0000_0013, 32'h0020_0013);
      check("in_ready_full", 32'(in_ready), 32'd0);
      fork
         push(2'b00, 32'd3, 32'h0000_0013, 32'h0030_0013);
         begin
            repeat (3) @(negedge clk);
            check("in_ready_held", 32'(in_ready), 32'd0);
            check("valid_held", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Simultaneous push and pop at count 1
      out_ready = 1'b0;
      push(2'b01, 32'hFFFF_FFF0, 32'h0000_2023, 32'hFE00_2823);
      out_ready = 1'b1;
      push(2'b11, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F);
      out_ready = 1'b0;
      @(negedge clk);
      check("count1_valid", 32'(out_valid), 32'd1);
      check("count1_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      drain();

      // Asynchronous reset with a full buffer
      out_ready = 1'b0;
      push(2'b00, 32'd5000, 32'h0000_0013, 32'h3880_0013);
      push(2'b11, 32'd4096, 32'h0000_006F, 32'h0000_106F);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_addr", out_addr, BASE);
      check("midrst_err_cnt", 32'(err_cnt), 32'd0);
      sbq.delete();
      exp_addr = BASE;
      exp_errcnt = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      push(2'b00, 32'd1, 32'h0000_0013, 32'h0010_0013);
      drain();

      // Randomized traffic with random backpressure
      rand_mode = 1;
      for (int k = 0; k < 300; k++) begin
         r   = $urandom;
         imm = 32'($signed(r) >>> $urandom_range(8, 24));
         if ($urandom_range(0, 1) != 0) imm[0] = 1'b0;
         s   = 2'($urandom_range(0, 3));
         r   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         push(s, imm, r, model_pack(s, imm, r));
      end
      rand_mode = 0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
